alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Request sequencer that owns the 32-bit unsigned ALU and adds a multi-cycle unsigned multiply on top of its single-cycle operations. It accepts one operation at a time over a valid/ready request port. Single ALU ops are passed through in one execute cycle. MUL is run as an iterative shift-add loop that issues one ALU ADD per cycle. Results return over a valid/ready response port. The ALU instance sits outside this block, beside it, connected through the `alu_*` port bundle.

## Interface
Parameters:
- `MUL_MAX_ITER`, default 32. Iteration bound for MUL; must equal the data width. Fixed at 32 for this block.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_op` in 4: 0-7 = ALU opcode (NOT, AND, OR, XOR, SHL, SHR, CUT, ADD); 8 = MUL; 9-15 = illegal.
- `req_a` in 32: operand A.
- `req_b` in 32: operand B.
- `req_cin` in 1: carry-in, used by ADD only.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_result` out 32: result.
- `rsp_cout` out 1: ADD carry-out; for MUL, the overflow flag (true product ≥ 2^32).
- `rsp_err` out 1: request had an illegal op.
- `busy` out 1: state ≠ IDLE.
- `alu_opcode` out 3: drives the ALU opcode.
- `alu_a`, `alu_b` out 32: drive the ALU operands.
- `alu_cin` out 1: drives the ALU carry-in.
- `alu_result` in 32: ALU result.
- `alu_cout` in 1: ALU carry-out (combinational).

## Operation
- **FSM states:** IDLE, EXEC, MUL, RESP.
- **Reset values:** state IDLE; `rsp_valid`=0, `rsp_result`=0, `rsp_cout`=0, `rsp_err`=0; all `alu_*` outputs 0.
- **Ready/busy:** `req_ready` = (state==IDLE) && !rst. `busy` = (state≠IDLE).
- **IDLE:** on `req_valid && req_ready`, register op, A, B and cin.
  - op 0-7 → EXEC.
  - op 8 → MUL; initialize acc=0, mcand=A, mplier=B, lost=0, ovf=0.
  - op 9-15 → RESP with result=0, cout=0, err=1. The ALU is not driven.
- **EXEC:** drive `alu_opcode`=op[2:0], `alu_a`=A, `alu_b`=B, `alu_cin`=cin. Capture `rsp_result`=`alu_result`. Capture `rsp_cout` = `alu_cout` when op=7, else 0. Set err=0. Go to RESP.
- **MUL**, one cycle per step:
  - If mplier==0: `rsp_result`=acc, `rsp_cout`=ovf, err=0; go to RESP. The ALU is not driven.
  - Otherwise:
    - Drive `alu_opcode`=3'b111, `alu_a`=acc, `alu_b` = mplier[0] ? mcand : 0, `alu_cin`=0.
    - acc ← `alu_result`.
    - ovf ← ovf | (mplier[0] & (`alu_cout` | lost)).
    - lost ← lost | mcand[31].
    - mcand ← mcand<<1.
    - mplier ← mplier>>1.
  - Loop runs at most 32 steps, because mplier becomes 0 after 32 shifts.
- **MUL arithmetic:** `rsp_result` = (A·B) mod 2^32. ovf=1 exactly when A·B ≥ 2^32.
- **RESP:** `rsp_valid`=1. Result fields hold stable until `rsp_valid && rsp_ready`. On that handshake go to IDLE and drop `rsp_valid`.
- **ALU drive outside EXEC and active MUL steps:** all `alu_*` outputs are 0.
- **Reset mid-operation:** `rst` in any state aborts the operation with no response. Registered request state is discarded.

## Timing
- Request accepted at edge T (handshake sampled at T).
- Single-op or illegal-op response: `rsp_valid` is high from edge T+2 for a legal op and from T+1 for an illegal op.
- MUL response: with k = index of the highest set bit of B, plus 1 (k=0 when B=0), `rsp_valid` is high from edge T+k+2.
  - B=0 → T+2.
  - B=1 → T+3.
  - B=0x8000_0000 → T+34.
- `rsp_ready` held high: RESP lasts one cycle; IDLE is next, so the next request can be accepted one cycle after the response handshake.
- Throughput: at most one operation in flight. No request is accepted while `busy`.
- `req_*` inputs are sampled only on the accept cycle; changes at other times are ignored.
- `rsp_ready` asserted in non-RESP states has no effect.

## Test plan
- Reset then ADD A=0xFFFF_FFFF, B=1, cin=0 → `rsp_result`=0, `rsp_cout`=1, `rsp_err`=0, `rsp_valid` at T+2. Check `req_ready`=0 while `rst`=1.
- Each op 0-6 with A=0xF0F0_1234, B=4 → results match the ALU op: SHL=0x0F01_2340, SHR=0x0F0F_0123, CUT=0x4; `rsp_cout`=0 throughout.
- MUL cases:
  - A=7, B=6 → 42, cout=0, valid at T+5.
  - A=0x1_0000, B=0x1_0000 → 0, cout=1.
  - A=0xFFFF_FFFF, B=0 → 0, cout=0, valid at T+2.
  - A=3, B=0x8000_0000 → 0x8000_0000, cout=1, valid at T+34.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after MUL A=5, B=5 → `rsp_valid` and result 25 stay stable; `req_ready`=0; `req_valid` pulses are ignored; after `rsp_ready`=1 the block is in IDLE the next cycle.
- `req_op`=12 → `rsp_err`=1, result 0, `rsp_valid` at T+1, `alu_*` stay 0.
- Assert `rst` during MUL step 10 of A=3, B=0xFFFF_FFFF → no `rsp_valid`, IDLE next cycle. A following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Request sequencer wrapping an external 32-bit ALU: single-cycle pass-through ops
// plus an iterative shift-add unsigned multiply built from one ALU ADD per step.
module alu_seq_ctrl #(
  parameter int unsigned MUL_MAX_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_cin,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_cout,
  output logic        rsp_err,
  output logic        busy,
  output logic [2:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  input  logic [31:0] alu_result,
  input  logic        alu_cout
);

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 3;
  localparam int unsigned IW  = $clog2(MUL_MAX_ITER + 1);

  localparam logic [3:0]     OP_MUL = 4'd8;
  localparam logic [OPW-1:0] OP_ADD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_RESP
  } state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  a_q, a_d;        // operand A; doubles as the shifting multiplicand
  logic [DW-1:0]  b_q, b_d;        // operand B; doubles as the shifting multiplier
  logic           cin_q, cin_d;
  logic [DW-1:0]  acc_q, acc_d;
  logic           lost_q, lost_d;
  logic           ovf_q, ovf_d;
  logic [IW-1:0]  iter_q, iter_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_result_q, rsp_result_d;
  logic           rsp_cout_q, rsp_cout_d;
  logic           rsp_err_q, rsp_err_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      acc_q        <= '0;
      lost_q       <= 1'b0;
      ovf_q        <= 1'b0;
      iter_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      acc_q        <= acc_d;
      lost_q       <= lost_d;
      ovf_q        <= ovf_d;
      iter_q       <= iter_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Next-state, datapath update and ALU drive
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    acc_d        = acc_q;
    lost_d       = lost_q;
    ovf_d        = ovf_q;
    iter_d       = iter_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_err_d    = rsp_err_q;
    alu_opcode   = '0;
    alu_a        = '0;
    alu_b        = '0;
    alu_cin      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = req_op[OPW-1:0];
          a_d    = req_a;
          b_d    = req_b;
          cin_d  = req_cin;
          acc_d  = '0;
          lost_d = 1'b0;
          ovf_d  = 1'b0;
          iter_d = '0;
          if (req_op < OP_MUL) begin
            state_d = S_EXEC;
          end else if (req_op == OP_MUL) begin
            state_d = S_MUL;
          end else begin
            rsp_result_d = '0;
            rsp_cout_d   = 1'b0;
            rsp_err_d    = 1'b1;
            rsp_valid_d  = 1'b1;
            state_d      = S_RESP;
          end
        end
      end

      S_EXEC: begin
        alu_opcode   = op_q;
        alu_a        = a_q;
        alu_b        = b_q;
        alu_cin      = cin_q;
        rsp_result_d = alu_result;
        rsp_cout_d   = (op_q == OP_ADD) & alu_cout;
        rsp_err_d    = 1'b0;
        rsp_valid_d  = 1'b1;
        state_d      = S_RESP;
      end

      S_MUL: begin
        // Multiplier exhausted (or iteration guard hit): the accumulator is the product
        if ((b_q == '0) || (iter_q == IW'(MUL_MAX_ITER))) begin
          rsp_result_d = acc_q;
          rsp_cout_d   = ovf_q;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          alu_opcode = OP_ADD;
          alu_a      = acc_q;
          alu_b      = b_q[0] ? a_q : '0;
          alu_cin    = 1'b0;
          acc_d      = alu_result;
          // A set multiplier bit whose partial product spilled past bit 31 overflows
          ovf_d      = ovf_q | (b_q[0] & (alu_cout | lost_q));
          lost_d     = lost_q | a_q[DW-1];
          a_d        = a_q << 1;
          b_d        = b_q >> 1;
          iter_d     = iter_q + IW'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: a behavioural ALU sits on the alu_* bundle and a
// reference model predicts every response, its latency and its flags.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_cout;
  logic        rsp_err;
  logic        busy;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_cin;
  logic [31:0] alu_result;
  logic        alu_cout;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.MUL_MAX_ITER(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_err(rsp_err), .busy(busy),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   acc_edge[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random backpressure, 2: driven by hand
  bit   seen = 1'b0;

  // ALU behaviour: {cout, result}
  function automatic logic [32:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin);
    logic [32:0] r;
    case (op)
      3'd0: r = {1'b0, ~a};
      3'd1: r = {1'b0, a & b};
      3'd2: r = {1'b0, a | b};
      3'd3: r = {1'b0, a ^ b};
      3'd4: r = {1'b0, a << b};
      3'd5: r = {1'b0, a >> b};
      3'd6: r = (b >= 32) ? {1'b0, a} : {1'b0, a & ((32'h1 << b) - 32'h1)};
      default: r = 33'(a) + 33'(b) + 33'(cin);
    endcase
    return r;
  endfunction

  always_comb {alu_cout, alu_result} = alu_fn(alu_opcode, alu_a, alu_b, alu_cin);

  function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic cin);
    exp_t e;
    logic [32:0] r;
    logic [63:0] p;
    int k;
    if (op < 4'd8) begin
      r = alu_fn(op[2:0], a, b, cin);
      e.res = r[31:0];
      e.cout = (op == 4'd7) ? r[32] : 1'b0;
      e.err = 1'b0;
      e.lat = 2;
    end else if (op == 4'd8) begin
      p = 64'(a) * 64'(b);
      k = 0;
      for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
      e.res = p[31:0];
      e.cout = (p[63:32] != 32'h0);
      e.err = 1'b0;
      e.lat = k + 2;
    end else begin
      e.res = '0;
      e.cout = 1'b0;
      e.err = 1'b1;
      e.lat = 1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard on each response handshake
  always @(negedge clk) begin
    if (rst) begin
      acc_edge.delete();
      seen = 1'b0;
      chk("req_ready_in_rst", 64'(req_ready), 64'd0);
    end else begin
      if (req_valid && req_ready) acc_edge.push_back(cyc + 1);
      if (rsp_valid) begin
        chk("alu_idle_in_resp", {alu_opcode, alu_cin, alu_a, alu_b} == '0, 64'd1);
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            if (acc_edge.size() != 0)
              chk("latency", 64'(cyc + 1 - acc_edge[0]), 64'(sb[0].lat));
            else
              chk("accept_seen", 64'd0, 64'd1);
          end
          chk("result", 64'(rsp_result), 64'(sb[0].res));
          chk("cout", 64'(rsp_cout), 64'(sb[0].cout));
          chk("err", 64'(rsp_err), 64'(sb[0].err));
          if (rsp_ready) begin
            void'(sb.pop_front());
            if (acc_edge.size() != 0) void'(acc_edge.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Consumer-side ready generator
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) rsp_ready = 1'b1;
      else if (rdy_mode == 1) rsp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic cin);
    int n = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (n < 100) sb.push_back(ref_model(op, a, b, cin));
    req_valid = 1'b0;
    req_op = 4'($urandom); req_a = $urandom; req_b = $urandom; req_cin = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int n;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_fields", {rsp_result, rsp_cout, rsp_err}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu", {alu_opcode, alu_cin, alu_a, alu_b} == '0, 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    send(4'd7, 32'hFFFF_FFFF, 32'h1, 1'b0);
    for (int i = 0; i < 7; i++) send(4'(i), 32'hF0F0_1234, 32'h4, 1'b0);
    send(4'd8, 32'd7, 32'd6, 1'b0);
    send(4'd8, 32'h1_0000, 32'h1_0000, 1'b0);
    send(4'd8, 32'hFFFF_FFFF, 32'h0, 1'b0);
    send(4'd8, 32'd3, 32'h8000_0000, 1'b0);
    send(4'd7, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    drain();

    // Response held off for five cycles while stray requests are offered
    rdy_mode = 2;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    send(4'd8, 32'd5, 32'd5, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 req_valid = 1'b1; req_op = 4'd7; req_a = 32'h1; req_b = 32'h1;
      @(negedge clk);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_valid_held", 64'(rsp_valid), 64'd1);
    end
    @(posedge clk);
    #1 req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_after", 64'(busy), 64'd0);
    chk("bp_req_ready_after", 64'(req_ready), 64'd1);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);
    rdy_mode = 0;

    send(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    drain();

    // Abort a long multiply during its tenth step
    send(4'd8, 32'd3, 32'hFFFF_FFFF, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    send(4'd7, 32'd2, 32'd3, 1'b0);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) op = 4'd8;
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) b = 32'h0;
      send(op, a, b, 1'($urandom));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
